run_expand: RTL and testbench
=============================

RUN_EXPAND -- requirements
Module: run_expand

Interface
REQ-001 Parameters: none; word width fixed at 32, run length field fixed at 5 bits.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-004 run_valid_i  input  1  run token offered.
REQ-005 run_ready_o  output  1  run token accepted when run_valid_i && run_ready_o at a rising edge.
REQ-006 run_value_i  input  1  bit value of the run.
REQ-007 run_len_i  input  5  run length minus one; the run has run_len_i+1 bits (1..32), same count encoding as cntb.
REQ-008 run_last_i  input  1  last run of a packet; a partial word is flushed after it.
REQ-009 word_o  output  32  assembled word, filled MSB-first.
REQ-010 word_bits_o  output  6  number of valid bits in word_o (1..32), left-aligned from bit 31.
REQ-011 word_valid_o  output  1  word offered.
REQ-012 word_ready_i  input  1  word consumed when word_valid_o && word_ready_i at a rising edge.

Function
REQ-013 Block is a run-length expander: the inverse of cntb; it writes runs of equal bits into words instead of counting them.
REQ-014 State machine states: FILL and EMIT; reset state is FILL.
REQ-015 run_ready_o = 1 in FILL and 0 in EMIT; word_valid_o = 1 in EMIT and 0 in FILL; both are decoded from registered state only.
REQ-016 Internal state: acc[31:0] accumulator, used[5:0] bits filled (0..31 in FILL), spill[5:0] pending carry bits, spill_val, spill_last.
REQ-017 On run accept in FILL, with n = run_len_i+1 and free = 32-used:
- If n < free: write n bits of run_value_i at acc[31-used] downward; used += n; stay in FILL unless run_last_i.
- If n == free: fill the word; go to EMIT.
- If n > free: write free bits; set spill = n-free, spill_val = run_value_i, spill_last = run_last_i; go to EMIT.
REQ-018 If run_last_i and n < free, go to EMIT with a partial word (word_bits_o = used+n).
REQ-019 Bits of word_o below the valid field SHALL be 0.
REQ-020 Latency: word_valid_o asserts in the cycle after the run-accept edge that completes or terminates the word.
REQ-021 word_o and word_bits_o SHALL hold stable while word_valid_o=1 and word_ready_i=0.
REQ-022 On word handshake with spill=0: clear acc; set used=0; go to FILL.
REQ-023 On word handshake with spill>0: load acc with spill bits of spill_val from bit 31 downward; set used=spill and clear spill.
- If spill_last: stay in EMIT, presenting the partial word (word_bits_o = spill).
- Otherwise: go to FILL.
REQ-024 A spill of 32 bits (used=0 is impossible in the spill case) SHALL NOT occur; spill is at most 31.
REQ-025 run_valid_i in EMIT is ignored (backpressure); the token SHALL remain held by the source.
REQ-026 No internal width truncation: used+n computed at 7 bits.

Reset
REQ-027 While rst_ni=0: state=FILL, acc=0, used=0, spill=0, spill_val=0, spill_last=0.
REQ-028 While rst_ni=0: outputs word_valid_o=0, run_ready_o=1, word_o=0, word_bits_o=0.
REQ-029 Reset asserted mid-packet or mid-EMIT discards all partial data; there is no output after release until new runs are accepted.

Verification
REQ-030 Runs (1,len=2),(0,len=0),(1,len=27) with no last -> one word 0xEFFFFFFF, bits=32, valid one cycle after the third accept.
REQ-031 Single run (1,len=3,last=1) -> word 0xF0000000, bits=4.
REQ-032 Runs (0,len=29),(1,len=4,last=1) -> first word 0x00000003 bits=32, then after the handshake word 0xE0000000 bits=3.
REQ-033 Hold word_ready_i=0 for 5 cycles with run_valid_i=1 -> run_ready_o=0 and word_o stable throughout; the run is accepted only after the handshake.
REQ-034 Runs (1,len=31) back-to-back ten times with word_ready_i=1 -> ten words 0xFFFFFFFF, one word per two cycles.
REQ-035 Assert rst_ni=0 after 20 of 32 bits are filled -> all outputs take reset values; a following (0,len=0,last=1) yields 0x00000000, bits=1.

Source files
------------

// File: rtl/run_expand.sv
// Run-length expander: turns (value, length) run tokens into 32-bit words filled MSB-first.
// A run that overflows the current word carries its remaining bits into the next word.
module run_expand (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_valid_i,
  output logic        run_ready_o,
  input  logic        run_value_i,
  input  logic [4:0]  run_len_i,
  input  logic        run_last_i,
  output logic [31:0] word_o,
  output logic [5:0]  word_bits_o,
  output logic        word_valid_o,
  input  logic        word_ready_i
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  used_q, used_d;
  logic [5:0]  spill_q, spill_d;
  logic        spill_val_q, spill_val_d;
  logic        spill_last_q, spill_last_d;

  logic [6:0]  run_n;
  logic [6:0]  fill_sum;
  logic [31:0] run_mask;
  logic [31:0] spill_fill;
  logic        run_accept;
  logic        word_accept;

  assign run_ready_o  = (state_q == FILL);
  assign word_valid_o = (state_q == EMIT);
  assign word_o       = acc_q;
  assign word_bits_o  = used_q;

  assign run_accept  = run_valid_i && run_ready_o;
  assign word_accept = word_valid_o && word_ready_i;

  // n leading ones shifted down past the filled bits; anything beyond bit 0 falls off,
  // which is exactly the part of an overflowing run that becomes the spill.
  always_comb begin
    run_n      = {2'b00, run_len_i} + 7'd1;
    fill_sum   = {1'b0, used_q} + run_n;
    run_mask   = (~(32'hFFFF_FFFF >> run_n)) >> used_q;
    spill_fill = spill_val_q ? ~(32'hFFFF_FFFF >> spill_q) : 32'h0000_0000;
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    used_d       = used_q;
    spill_d      = spill_q;
    spill_val_d  = spill_val_q;
    spill_last_d = spill_last_q;

    case (state_q)
      FILL: begin
        if (run_accept) begin
          if (run_value_i) begin
            acc_d = acc_q | run_mask;
          end
          if (fill_sum < 7'd32) begin
            used_d = fill_sum[5:0];
            if (run_last_i) begin
              state_d = EMIT;
            end
          end else if (fill_sum == 7'd32) begin
            used_d  = 6'd32;
            state_d = EMIT;
          end else begin
            used_d       = 6'd32;
            spill_d      = 6'(fill_sum - 7'd32);
            spill_val_d  = run_value_i;
            spill_last_d = run_last_i;
            state_d      = EMIT;
          end
        end
      end

      EMIT: begin
        if (word_accept) begin
          if (spill_q == '0) begin
            acc_d   = '0;
            used_d  = '0;
            state_d = FILL;
          end else begin
            acc_d        = spill_fill;
            used_d       = spill_q;
            spill_d      = '0;
            spill_last_d = 1'b0;
            // A carried tail of a last run is already a complete packet end: show it now.
            state_d      = spill_last_q ? EMIT : FILL;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FILL;
      acc_q        <= '0;
      used_q       <= '0;
      spill_q      <= '0;
      spill_val_q  <= 1'b0;
      spill_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      used_q       <= used_d;
      spill_q      <= spill_d;
      spill_val_q  <= spill_val_d;
      spill_last_q <= spill_last_d;
    end
  end

endmodule

// File: tb/tb_run_expand.sv
// Scoreboard bench for run_expand: expected words are queued as runs are driven
// and compared when the DUT hands a word over.
module tb_run_expand;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        run_valid_i = 1'b0;
  logic        run_ready_o;
  logic        run_value_i = 1'b0;
  logic [4:0]  run_len_i = '0;
  logic        run_last_i = 1'b0;
  logic [31:0] word_o;
  logic [5:0]  word_bits_o;
  logic        word_valid_o;
  logic        word_ready_i = 1'b0;

  typedef struct packed {
    logic [31:0] w;
    logic [5:0]  b;
  } exp_t;

  exp_t exp_q[$];
  int   hs_cyc[$];
  logic mbits[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  run_expand dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .run_valid_i  (run_valid_i),
    .run_ready_o  (run_ready_o),
    .run_value_i  (run_value_i),
    .run_len_i    (run_len_i),
    .run_last_i   (run_last_i),
    .word_o       (word_o),
    .word_bits_o  (word_bits_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake is decided on the coming rising edge; sample its inputs at the falling edge.
  always @(negedge clk_i) begin
    if (rst_ni && word_valid_o && word_ready_i) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_val("unexpected_word", {63'd0, word_valid_o}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("word", {32'd0, word_o}, {32'd0, e.w});
        check_val("bits", {58'd0, word_bits_o}, {58'd0, e.b});
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (rand_rdy) word_ready_i = 1'($urandom_range(0, 1));
  end

  task automatic push_exp(input logic [31:0] w, input logic [5:0] b);
    exp_t e;
    e.w = w;
    e.b = b;
    exp_q.push_back(e);
  endtask

  // Bit-serial reference: collect bits, cut 32-bit words, flush a partial word on last.
  task automatic model_run(input logic v, input logic [4:0] len, input logic last);
    logic [31:0] w;
    int unsigned nb;
    for (int i = 0; i <= int'(len); i++) mbits.push_back(v);
    while (mbits.size() >= 32) begin
      w = '0;
      for (int i = 0; i < 32; i++) w[31-i] = mbits.pop_front();
      push_exp(w, 6'd32);
    end
    if (last && mbits.size() > 0) begin
      w  = '0;
      nb = mbits.size();
      for (int i = 0; i < int'(nb); i++) w[31-i] = mbits.pop_front();
      push_exp(w, 6'(nb));
    end
  endtask

  // Returns at accept edge + 1; waited counts falling edges that saw run_ready_o low.
  task automatic wait_accept(output int waited);
    waited = 0;
    forever begin
      @(negedge clk_i);
      if (run_ready_o) break;
      waited++;
      if (waited > 200) begin
        $display("FAIL accept_timeout: got no run_ready_o expected accept within 200 cycles");
        n_tests++;
        n_fail++;
        break;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_run(input logic v, input logic [4:0] len, input logic last);
    int w;
    run_valid_i = 1'b1;
    run_value_i = v;
    run_len_i   = len;
    run_last_i  = last;
    wait_accept(w);
    run_valid_i = 1'b0;
    run_last_i  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk_i);
    check_val("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int w;
    #2;
    check_val("rst_valid", {63'd0, word_valid_o}, 64'd0);
    check_val("rst_ready", {63'd0, run_ready_o}, 64'd1);
    check_val("rst_word", {32'd0, word_o}, 64'd0);
    check_val("rst_bits", {58'd0, word_bits_o}, 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    word_ready_i = 1'b1;

    // Three runs filling exactly one word
    push_exp(32'hEFFF_FFFF, 6'd32);
    send_run(1'b1, 5'd2, 1'b0);
    send_run(1'b0, 5'd0, 1'b0);
    send_run(1'b1, 5'd27, 1'b0);
    check_val("lat_full", {63'd0, word_valid_o}, 64'd1);
    wait_drain();

    // Single short last run
    push_exp(32'hF000_0000, 6'd4);
    send_run(1'b1, 5'd3, 1'b1);
    check_val("lat_partial", {63'd0, word_valid_o}, 64'd1);
    wait_drain();

    // Overflow with last: spilled tail becomes its own partial word
    push_exp(32'h0000_0003, 6'd32);
    push_exp(32'hE000_0000, 6'd3);
    send_run(1'b0, 5'd29, 1'b0);
    send_run(1'b1, 5'd4, 1'b1);
    wait_drain();

    // Backpressure: next run offered while the word is held
    word_ready_i = 1'b0;
    push_exp(32'hFFFF_FFFF, 6'd32);
    push_exp(32'h0000_0000, 6'd32);
    send_run(1'b1, 5'd31, 1'b0);
    run_valid_i = 1'b1;
    run_value_i = 1'b0;
    run_len_i   = 5'd31;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_val("bp_ready", {63'd0, run_ready_o}, 64'd0);
      check_val("bp_valid", {63'd0, word_valid_o}, 64'd1);
      check_val("bp_word", {32'd0, word_o}, 64'hFFFF_FFFF);
    end
    @(posedge clk_i);
    #1;
    word_ready_i = 1'b1;
    wait_accept(w);
    run_valid_i = 1'b0;
    check_val("bp_wait", 64'(w), 64'd1);
    wait_drain();

    // Ten full-word runs back to back
    hs_cyc.delete();
    for (int i = 0; i < 10; i++) push_exp(32'hFFFF_FFFF, 6'd32);
    for (int i = 0; i < 10; i++) send_run(1'b1, 5'd31, 1'b0);
    wait_drain();
    check_val("rate_count", 64'(hs_cyc.size()), 64'd10);
    for (int i = 1; i < 10 && i < hs_cyc.size(); i++)
      check_val("rate_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd2);

    // Reset in the middle of a word discards it
    send_run(1'b1, 5'd19, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_val("mrst_valid", {63'd0, word_valid_o}, 64'd0);
    check_val("mrst_ready", {63'd0, run_ready_o}, 64'd1);
    check_val("mrst_word", {32'd0, word_o}, 64'd0);
    check_val("mrst_bits", {58'd0, word_bits_o}, 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    check_val("mrst_idle", {63'd0, word_valid_o}, 64'd0);
    @(posedge clk_i);
    #1;
    push_exp(32'h0000_0000, 6'd1);
    send_run(1'b0, 5'd0, 1'b1);
    wait_drain();

    // Random packets against the bit-serial model, random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic v, l;
      logic [4:0] len;
      v   = 1'($urandom_range(0, 1));
      len = 5'($urandom_range(0, 31));
      l   = (i == 79) || ($urandom_range(0, 5) == 0);
      model_run(v, len, l);
      send_run(v, len, l);
    end
    wait_drain();
    rand_rdy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1);
  end

endmodule
